// File: rtl/dct_pkg.sv
// Shared constants for the 8x8 DCT multiply-accumulate datapath.
//   PIX_W / COEF_W / ACC_W / OUT_W : default datapath widths
//   C0_SCALE   : 1/sqrt(2) in Q.8, applied to the u==0 / v==0 terms
//   UNIT_SCALE : 1.0 in Q.8, applied to all other frequency indices
//   OUT_SHIFT  : right shift that returns the scaled sum to output units
//   PIPE_LAT   : edges from the last sample to the coefficient pulse
package dct_pkg;
  localparam int PIX_W       = 8;
  localparam int COEF_W      = 9;
  localparam int ACC_W       = 32;
  localparam int OUT_W       = 12;
  localparam int C0_SCALE    = 181;
  localparam int UNIT_SCALE  = 256;
  localparam int OUT_SHIFT   = 32;
  localparam int PIPE_LAT    = 3;
  localparam int MAX_SAMPLES = 64;
endpackage

// File: rtl/dct_cos_rom.sv
// Combinational cosine table: coef = round(128*cos((2n+1)*k*pi/16)), signed Q1.7.
//   k    in  3       frequency index (u or v)
//   n    in  3       spatial index (x or y)
//   coef out COEF_W  signed cosine value
module dct_cos_rom #(
  parameter int COEF_W = dct_pkg::COEF_W
) (
  input  logic [2:0]               k,
  input  logic [2:0]               n,
  output logic signed [COEF_W-1:0] coef
);

  // Magnitudes of 128*cos(m*pi/16) for m = 0..8; the rest of the circle
  // is folded onto this quarter wave.
  function automatic logic [7:0] cos_mag(input logic [3:0] m);
    case (m)
      4'd0:    cos_mag = 8'd128;
      4'd1:    cos_mag = 8'd126;
      4'd2:    cos_mag = 8'd118;
      4'd3:    cos_mag = 8'd106;
      4'd4:    cos_mag = 8'd91;
      4'd5:    cos_mag = 8'd71;
      4'd6:    cos_mag = 8'd49;
      4'd7:    cos_mag = 8'd25;
      default: cos_mag = 8'd0;
    endcase
  endfunction

  logic [6:0] angle;
  logic [4:0] m;
  logic [4:0] fold;
  logic       neg;
  logic signed [COEF_W-1:0] mag;

  always_comb begin
    angle = {3'b000, n, 1'b1} * {4'b0000, k};
    // Angle in units of pi/16, taken modulo a full turn.
    m     = angle[4:0];
    fold  = m;
    neg   = 1'b0;
    if (m <= 5'd8) begin
      fold = m;
    end else if (m <= 5'd16) begin
      fold = 5'd16 - m;
      neg  = 1'b1;
    end else if (m <= 5'd24) begin
      fold = m - 5'd16;
      neg  = 1'b1;
    end else begin
      fold = 5'd0 - m;
    end
    mag  = COEF_W'(cos_mag(fold[3:0]));
    coef = neg ? -mag : mag;
  end

endmodule

// File: rtl/dct_mac_unit.sv
// Datapath for one 2-D DCT coefficient: accumulates 64 pixel*cos*cos products,
// then scales, rounds and saturates the sum and emits it with a one-cycle pulse.
//   clock, reset_MAC (async, active-low; also per-coefficient clear)
//   active_MAC / read_enable / ready : sample strobe, memory read flag, last-sample flag
//   u, v, x, y, pixel_in             : indices and pixel for the current sample
//   coef_out, coef_index, coef_valid : result, its {v,u}, and update pulse
//   sample_count                     : samples accepted since reset_MAC
//   overrun_err, underrun_err, proto_err : sticky protocol flags
//   busy                             : samples in the pipeline or result pending
module dct_mac_unit
  import dct_pkg::*;
#(
  parameter int PIX_W  = dct_pkg::PIX_W,
  parameter int COEF_W = dct_pkg::COEF_W,
  parameter int ACC_W  = dct_pkg::ACC_W,
  parameter int OUT_W  = dct_pkg::OUT_W
) (
  input  logic                    clock,
  input  logic                    reset_MAC,
  input  logic                    active_MAC,
  input  logic                    read_enable,
  input  logic                    ready,
  input  logic [2:0]              u,
  input  logic [2:0]              v,
  input  logic [2:0]              x,
  input  logic [2:0]              y,
  input  logic [PIX_W-1:0]        pixel_in,
  output logic signed [OUT_W-1:0] coef_out,
  output logic [5:0]              coef_index,
  output logic                    coef_valid,
  output logic [6:0]              sample_count,
  output logic                    overrun_err,
  output logic                    underrun_err,
  output logic                    proto_err,
  output logic                    busy
);

  localparam int P1_W  = PIX_W + COEF_W + 1;
  localparam int P2_W  = P1_W + COEF_W;
  localparam int SCL_W = 48;
  localparam int Q_W   = SCL_W - OUT_SHIFT + 1;

  localparam logic [6:0] FULL = 7'(MAX_SAMPLES);
  localparam logic signed [SCL_W:0] RND_HALF =
    {{(SCL_W - OUT_SHIFT + 1){1'b0}}, 1'b1, {(OUT_SHIFT - 1){1'b0}}};
  localparam logic signed [Q_W-1:0] SAT_HI = Q_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [Q_W-1:0] SAT_LO = -SAT_HI - Q_W'(1);

  // Add one half LSB of the output grid, then drop the fractional bits.
  function automatic logic signed [Q_W-1:0] round_shift(input logic signed [SCL_W-1:0] r);
    logic signed [SCL_W:0] t;
    t = $signed({r[SCL_W-1], r}) + RND_HALF;
    return t[SCL_W:OUT_SHIFT];
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [Q_W-1:0] q);
    logic signed [Q_W-1:0] c;
    if (q > SAT_HI)      c = SAT_HI;
    else if (q < SAT_LO) c = SAT_LO;
    else                 c = q;
    return c[OUT_W-1:0];
  endfunction

  logic signed [COEF_W-1:0] cu, cv;

  dct_cos_rom #(.COEF_W(COEF_W)) u_rom_u (.k(u), .n(x), .coef(cu));
  dct_cos_rom #(.COEF_W(COEF_W)) u_rom_v (.k(v), .n(y), .coef(cv));

  logic                     accept;
  logic [5:0]               idx_reg;
  logic [5:0]               idx_now;
  logic [6:0]               count_after;

  logic [PIX_W-1:0]         pix_p0;
  logic signed [COEF_W-1:0] cu_p0, cv_p0, cv_p1;
  logic signed [P1_W-1:0]   p1_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic                     vld_p0, vld_p1, vld_p2;

  logic [2:0]               pend;
  logic [5:0]               idx_pend [3];

  logic signed [P1_W-1:0]   p1_d;
  logic signed [P2_W-1:0]   p2_d;
  logic signed [SCL_W-1:0]  su, sv, scaled;

  assign accept      = active_MAC && (sample_count != FULL);
  assign count_after = sample_count + {6'd0, accept};
  // A ready on the very first sample must see that sample's indices.
  assign idx_now     = (accept && sample_count == 7'd0) ? {v, u} : idx_reg;

  assign p1_d = P1_W'($signed({1'b0, pix_p0})) * P1_W'(cu_p0);
  assign p2_d = P2_W'(p1_p1) * P2_W'(cv_p1);

  assign su     = (idx_pend[2][2:0] == 3'd0) ? SCL_W'(C0_SCALE) : SCL_W'(UNIT_SCALE);
  assign sv     = (idx_pend[2][5:3] == 3'd0) ? SCL_W'(C0_SCALE) : SCL_W'(UNIT_SCALE);
  assign scaled = SCL_W'(acc_p2) * su * sv;

  assign busy = vld_p0 || vld_p1 || vld_p2 || (|pend);

  always_ff @(posedge clock or negedge reset_MAC) begin
    if (!reset_MAC) begin
      sample_count <= '0;
      idx_reg      <= '0;
      overrun_err  <= 1'b0;
      underrun_err <= 1'b0;
      proto_err    <= 1'b0;
      pix_p0       <= '0;
      cu_p0        <= '0;
      cv_p0        <= '0;
      vld_p0       <= 1'b0;
      p1_p1        <= '0;
      cv_p1        <= '0;
      vld_p1       <= 1'b0;
      acc_p2       <= '0;
      vld_p2       <= 1'b0;
      pend         <= '0;
      idx_pend[0]  <= '0;
      idx_pend[1]  <= '0;
      idx_pend[2]  <= '0;
      coef_out     <= '0;
      coef_index   <= '0;
      coef_valid   <= 1'b0;
    end else begin
      sample_count <= count_after;
      if (accept && sample_count == 7'd0) idx_reg <= {v, u};
      if (active_MAC && sample_count == FULL) overrun_err <= 1'b1;
      if (ready && count_after < FULL) underrun_err <= 1'b1;
      if (active_MAC && !read_enable) proto_err <= 1'b1;

      // Stage 1: capture pixel and both cosine factors
      vld_p0 <= accept;
      if (accept) begin
        pix_p0 <= pixel_in;
        cu_p0  <= cu;
        cv_p0  <= cv;
      end

      // Stage 2: pixel * cos_u
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        p1_p1 <= p1_d;
        cv_p1 <= cv_p0;
      end

      // Stage 3: accumulate (pixel * cos_u) * cos_v
      vld_p2 <= vld_p1;
      if (vld_p1) acc_p2 <= acc_p2 + ACC_W'(p2_d);

      // Pending-ready line: each ready reaches the output once stage 3 has drained
      pend        <= {pend[1:0], ready};
      idx_pend[0] <= idx_now;
      idx_pend[1] <= idx_pend[0];
      idx_pend[2] <= idx_pend[1];

      // Output: scale, round, saturate
      coef_valid <= pend[2];
      if (pend[2]) begin
        coef_out   <= saturate(round_shift(scaled));
        coef_index <= idx_pend[2];
      end
    end
  end

endmodule

// File: tb/tb_dct_mac_unit.sv
module tb_dct_mac_unit;

  logic              clock = 1'b0;
  logic              reset_MAC;
  logic              active_MAC;
  logic              read_enable;
  logic              ready;
  logic [2:0]        u, v, x, y;
  logic [7:0]        pixel_in;
  logic signed [11:0] coef_out;
  logic [5:0]        coef_index;
  logic              coef_valid;
  logic [6:0]        sample_count;
  logic              overrun_err;
  logic              underrun_err;
  logic              proto_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clock = ~clock;

  always @(negedge clock) if (coef_valid === 1'b1) pulses++;

  dct_mac_unit dut (
    .clock(clock), .reset_MAC(reset_MAC), .active_MAC(active_MAC),
    .read_enable(read_enable), .ready(ready),
    .u(u), .v(v), .x(x), .y(y), .pixel_in(pixel_in),
    .coef_out(coef_out), .coef_index(coef_index), .coef_valid(coef_valid),
    .sample_count(sample_count), .overrun_err(overrun_err),
    .underrun_err(underrun_err), .proto_err(proto_err), .busy(busy)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic act, input logic re, input logic rdy,
                      input logic [2:0] uu, input logic [2:0] vv,
                      input logic [2:0] xx, input logic [2:0] yy,
                      input logic [7:0] pix);
    active_MAC = act; read_enable = re; ready = rdy;
    u = uu; v = vv; x = xx; y = yy; pixel_in = pix;
    @(negedge clock);
  endtask

  task automatic idle();
    active_MAC = 1'b0; read_enable = 1'b0; ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_MAC = 1'b0;
    @(negedge clock);
    reset_MAC = 1'b1;
  endtask

  // n samples scanning x then y; ramp=1 uses pixel x+8y, else pixel pc.
  task automatic run_coef(input logic [2:0] uu, input logic [2:0] vv, input int n,
                          input bit ramp, input logic [7:0] pc, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      logic [2:0] xx, yy;
      logic [7:0] pix;
      xx  = 3'(i % 8);
      yy  = 3'(i / 8);
      pix = ramp ? 8'(i) : pc;
      step(1'b1, 1'b1, rdy_last && (i == n - 1), uu, vv, xx, yy, pix);
    end
  endtask

  // Called at the negedge right after the ready edge; returns edges until the pulse.
  task automatic wait_result(output int lat);
    idle();
    lat = 0;
    while (coef_valid !== 1'b1 && lat < 10) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int lat, p0, total, flag_or;
    real model, d, cu_r, cv_r;

    reset_MAC = 1'b0;
    idle();
    u = 0; v = 0; x = 0; y = 0; pixel_in = 0;
    @(negedge clock);
    #1;
    check("rst_coef_out", coef_out, 0);
    check("rst_coef_valid", coef_valid, 0);
    check("rst_count", sample_count, 0);
    check("rst_flags", {overrun_err, underrun_err, proto_err}, 0);
    check("rst_busy", busy, 0);
    @(negedge clock);
    reset_MAC = 1'b1;

    // DC of a flat 255 block
    do_reset();
    run_coef(3'd0, 3'd0, 64, 1'b0, 8'd255, 1'b1);
    wait_result(lat);
    check("t2_latency", lat, 3);
    check("t2_coef", coef_out, 2040);
    check("t2_index", coef_index, 0);
    check("t2_count", sample_count, 64);
    check("t2_flags", {overrun_err, underrun_err, proto_err}, 0);
    @(negedge clock);
    check("t2_pulse_width", coef_valid, 0);
    check("t2_busy_idle", busy, 0);

    // Mid-run reset: extra sample with ready in flight, then clear
    step(1'b1, 1'b0, 1'b1, 3'd2, 3'd3, 3'd0, 3'd0, 8'd255);
    idle();
    check("t1_busy_before", busy, 1);
    check("t1_flags_before", {overrun_err, proto_err}, 2'b11);
    p0 = pulses;
    reset_MAC = 1'b0;
    #1;
    check("t1_coef_out", coef_out, 0);
    check("t1_index", coef_index, 0);
    check("t1_count", sample_count, 0);
    check("t1_flags", {overrun_err, underrun_err, proto_err}, 0);
    check("t1_busy", busy, 0);
    check("t1_valid", coef_valid, 0);
    @(negedge clock);
    reset_MAC = 1'b1;
    repeat (6) @(negedge clock);
    check("t1_no_pulse", pulses - p0, 0);

    // Flat 128 block, then u=1 on flat 100 (odd cosine sum cancels)
    do_reset();
    run_coef(3'd0, 3'd0, 64, 1'b0, 8'd128, 1'b1);
    wait_result(lat);
    check("t3a_coef", coef_out, 1024);
    do_reset();
    run_coef(3'd1, 3'd0, 64, 1'b0, 8'd100, 1'b1);
    wait_result(lat);
    check("t3b_latency", lat, 3);
    check("t3b_coef", coef_out, 0);
    check("t3b_index", coef_index, 1);

    // Overrun: 65th sample dropped, ready on it
    do_reset();
    run_coef(3'd0, 3'd0, 64, 1'b0, 8'd255, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 8'd255);
    wait_result(lat);
    check("t5_latency", lat, 3);
    check("t5_coef", coef_out, 2040);
    check("t5_overrun", overrun_err, 1);
    check("t5_count", sample_count, 64);
    check("t5_underrun", underrun_err, 0);

    // Underrun: ready after 10 samples
    do_reset();
    run_coef(3'd0, 3'd0, 10, 1'b0, 8'd255, 1'b1);
    wait_result(lat);
    check("t5u_latency", lat, 3);
    check("t5u_coef", coef_out, 319);
    check("t5u_underrun", underrun_err, 1);
    check("t5u_overrun", overrun_err, 0);

    // Protocol error, then reset one cycle after ready drops the result
    do_reset();
    step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd7);
    idle();
    @(negedge clock);
    check("t6_proto", proto_err, 1);
    check("t6_proto_only", {overrun_err, underrun_err}, 0);
    do_reset();
    run_coef(3'd0, 3'd0, 64, 1'b0, 8'd255, 1'b1);
    idle();
    @(negedge clock);
    p0 = pulses;
    reset_MAC = 1'b0;
    @(negedge clock);
    reset_MAC = 1'b1;
    repeat (6) @(negedge clock);
    check("t6_dropped", pulses - p0, 0);
    check("t6_coef_out", coef_out, 0);
    check("t6_busy", busy, 0);

    // Full 64-coefficient sweep over the x+8y ramp
    p0 = pulses;
    total = 0;
    flag_or = 0;
    for (int vv = 0; vv < 8; vv++) begin
      for (int uu = 0; uu < 8; uu++) begin
        do_reset();
        run_coef(3'(uu), 3'(vv), 64, 1'b1, 8'd0, 1'b1);
        wait_result(lat);
        model = 0.0;
        for (int yy = 0; yy < 8; yy++)
          for (int xx = 0; xx < 8; xx++)
            model += real'(xx + 8 * yy)
                   * $cos(real'((2 * xx + 1) * uu) * 3.14159265358979 / 16.0)
                   * $cos(real'((2 * yy + 1) * vv) * 3.14159265358979 / 16.0);
        cu_r  = (uu == 0) ? 0.70710678118655 : 1.0;
        cv_r  = (vv == 0) ? 0.70710678118655 : 1.0;
        model = model * cu_r * cv_r / 4.0;
        d     = real'(coef_out) - model;
        if (d < 0.0) d = -d;
        checks++;
        assert (d <= 1.0)
        else begin
          errors++;
          $error("FAIL t4_coef u=%0d v=%0d: observed %0d expected %f (+-1)", uu, vv, coef_out, model);
        end
        check("t4_index", coef_index, 32'((vv << 3) | uu));
        total   += int'(sample_count);
        flag_or |= int'({overrun_err, underrun_err, proto_err});
      end
    end
    repeat (3) @(negedge clock);
    check("t4_pulses", pulses - p0, 64);
    check("t4_samples", total, 4096);
    check("t4_flags", flag_or, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
